// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage and the decode/execute stages it feeds:
// FSM encoding, halt sentinel and instruction field positions.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    localparam int OP_BIT   = 31;
    localparam int DEST_MSB = 23;
    localparam int DEST_LSB = 16;
    localparam int OPA_MSB  = 15;
    localparam int OPA_LSB  = 8;
    localparam int OPB_MSB  = 7;
    localparam int OPB_LSB  = 0;

    function automatic logic is_halt(input logic [31:0] word);
        return word == HALT_WORD;
    endfunction

    // 1 = add, 0 = and
    function automatic logic instr_op(input logic [31:0] word);
        return word[OP_BIT];
    endfunction

    function automatic logic [7:0] instr_dest(input logic [31:0] word);
        return word[DEST_MSB:DEST_LSB];
    endfunction

    function automatic logic [15:0] instr_operands(input logic [31:0] word);
        return {word[OPA_MSB:OPA_LSB], word[OPB_MSB:OPB_LSB]};
    endfunction

endpackage

// File: rtl/fetch_stage_queue.sv
// Small synchronous FIFO holding {pc, instr} pairs; the head entry is read
// combinationally so the downstream handshake sees it in the same cycle.
module fetch_queue #(
    parameter int W     = 40,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (do_push && wr_ptr_reg == PW'(gi)) begin
                    mem[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;
    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: loadable instruction memory, PC and FSM streaming words to
// decode/execute through a credit-controlled prefetch queue.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int IMEM_DEPTH = 1 << ADDR_W,
    parameter int Q_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    input  logic              start,
    input  logic [ADDR_W-1:0] last_pc,
    output logic [31:0]       instr_out,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc_out,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(Q_DEPTH) + 1;
    localparam int QW = ADDR_W + 32;

    fetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] last_pc_reg;
    logic [ADDR_W-1:0] rd_pc_reg;
    logic              inflight_reg;

    logic [31:0]       imem [IMEM_DEPTH];
    logic [31:0]       rdata_reg;

    logic [QW-1:0]     q_head;
    logic [CW-1:0]     q_count;
    logic              q_empty;
    logic              q_full;
    logic [CW:0]       occupancy;

    logic              idle_like;
    logic              accept_start;
    logic              load_we;
    logic              halt_ret;
    logic              push;
    logic              pop;
    logic              credit_ok;
    logic              issue;

    assign idle_like    = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
    assign accept_start = idle_like && start;
    assign load_we      = reset && idle_like && load_en;

    // A returned halt word blocks the read that would otherwise issue this cycle,
    // so nothing is ever left in flight behind it.
    assign halt_ret  = inflight_reg && is_halt(rdata_reg);
    assign push      = inflight_reg && !halt_ret;
    assign pop       = !q_empty && instr_ready;
    assign occupancy = {1'b0, q_count} + {{CW{1'b0}}, inflight_reg};
    assign credit_ok = !q_full && (occupancy < (CW + 1)'(Q_DEPTH));
    assign issue     = (state_reg == ST_FETCH) && !halt_ret && credit_ok;

    always_ff @(posedge clk) begin
        if (load_we) begin
            imem[load_addr] <= load_data;
        end
        rdata_reg <= imem[pc_reg];
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = ST_FETCH;
                    pc_next    = '0;
                end
            end
            ST_FETCH: begin
                if (halt_ret) begin
                    state_next = ST_DRAIN;
                    pc_next    = rd_pc_reg;
                end else if (issue) begin
                    pc_next = pc_reg + ADDR_W'(1);
                    if (pc_reg == last_pc_reg) state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (halt_ret) pc_next = rd_pc_reg;
                // Finish in the cycle the last queued word leaves.
                if (!inflight_reg && q_count == CW'(pop)) state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            pc_reg       <= '0;
            last_pc_reg  <= '0;
            rd_pc_reg    <= '0;
            inflight_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            inflight_reg <= issue;
            if (issue)        rd_pc_reg   <= pc_reg;
            if (accept_start) last_pc_reg <= last_pc;
        end
    end

    fetch_queue #(
        .W     (QW),
        .DEPTH (Q_DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({rd_pc_reg, rdata_reg}),
        .pop       (pop),
        .head      (q_head),
        .count     (q_count),
        .empty     (q_empty),
        .full      (q_full)
    );

    assign instr_valid = !q_empty;
    assign instr_out   = q_empty ? 32'd0 : q_head[31:0];
    assign pc_out      = q_empty ? '0 : q_head[QW-1:32];
    assign busy        = (state_reg == ST_FETCH) || (state_reg == ST_DRAIN);
    assign done        = (state_reg == ST_DONE);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table for the basic and
// stalled runs, then hand-written halt, reset, disturbance and full-memory runs.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_en = 1'b0;
    logic [7:0]  load_addr = 8'd0;
    logic [31:0] load_data = 32'd0;
    logic        start = 1'b0;
    logic [7:0]  last_pc = 8'd0;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [7:0]  pc_out;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .start       (start),
        .last_pc     (last_pc),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_out      (pc_out),
        .busy        (busy),
        .done        (done)
    );

    typedef struct {
        bit          start;
        bit          ready;
        bit          valid;
        logic [31:0] instr;
        logic [7:0]  pc;
        bit          busy;
        bit          done;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] prog [256];
    int          total = 0;
    int          passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_en   = 1'b0;
    endtask

    task automatic add(input bit s, input bit r, input bit v, input logic [31:0] i,
                       input logic [7:0] p, input bit b, input bit d);
        vec_t e;
        e.start = s; e.ready = r; e.valid = v; e.instr = i; e.pc = p; e.busy = b; e.done = d;
        tbl.push_back(e);
    endtask

    task automatic check_idle(input string tag, input bit exp_done);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_instr"}, instr_out, 32'd0);
        chk({tag, "_pc"}, {24'd0, pc_out}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
    endtask

    // Pulses start, then follows the run until done, checking each transfer
    // against prog[] and the hold rule while stalled.
    task automatic run_collect(input int n_expect, input int max_cycles,
                               input bit rand_ready, input bit disturb);
        int          got = 0;
        bit          stalled = 1'b0;
        bit          done_seen = 1'b0;
        logic [31:0] held_i = 32'd0;
        logic [7:0]  held_pc = 8'd0;
        start       = 1'b1;
        instr_ready = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < max_cycles && !done_seen; c++) begin
            instr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (disturb && c == 2) begin
                start     = 1'b1;
                last_pc   = 8'd0;
                load_en   = 1'b1;
                load_addr = 8'd1;
                load_data = 32'hDEAD_BEEF;
            end
            if (stalled) begin
                chk("hold_valid", {31'd0, instr_valid}, 32'd1);
                chk("hold_instr", instr_out, held_i);
                chk("hold_pc", {24'd0, pc_out}, {24'd0, held_pc});
            end
            if (instr_valid && instr_ready) begin
                $display("xfer %0d pc=%0d instr=%h", got, pc_out, instr_out);
                chk("xfer_pc", {24'd0, pc_out}, {24'd0, got[7:0]});
                chk("xfer_instr", instr_out, prog[got[7:0]]);
                got++;
            end
            stalled = instr_valid && !instr_ready;
            held_i  = instr_out;
            held_pc = pc_out;
            if (done) done_seen = 1'b1;
            step();
            start   = 1'b0;
            load_en = 1'b0;
        end
        chk("done_reached", {31'd0, done_seen}, 32'd1);
        chk("xfer_count", got, n_expect);
    endtask

    initial begin
        // Power-on reset
        reset = 1'b0;
        repeat (3) step();
        check_idle("reset", 1'b0);
        reset = 1'b1;
        step();

        load(8'd0, 32'h8005_0304);
        load(8'd1, 32'h0006_0F3C);
        load(8'd2, 32'h8007_FF01);
        last_pc = 8'd2;

        // Run 1: ready held high, from IDLE
        add(1, 1, 0, 32'h0, 8'd0, 0, 0);
        add(0, 1, 0, 32'h0, 8'd0, 1, 0);
        add(0, 1, 0, 32'h0, 8'd0, 1, 0);
        add(0, 1, 1, 32'h8005_0304, 8'd0, 1, 0);
        add(0, 1, 1, 32'h0006_0F3C, 8'd1, 1, 0);
        add(0, 1, 1, 32'h8007_FF01, 8'd2, 1, 0);
        add(0, 1, 0, 32'h0, 8'd0, 0, 1);
        // Run 2: restart from DONE, ready low for cycles 0-10
        add(1, 0, 0, 32'h0, 8'd0, 0, 1);
        add(0, 0, 0, 32'h0, 8'd0, 1, 0);
        add(0, 0, 0, 32'h0, 8'd0, 1, 0);
        for (int c = 3; c <= 10; c++) add(0, 0, 1, 32'h8005_0304, 8'd0, 1, 0);
        add(0, 1, 1, 32'h8005_0304, 8'd0, 1, 0);
        add(0, 1, 1, 32'h0006_0F3C, 8'd1, 1, 0);
        add(0, 1, 1, 32'h8007_FF01, 8'd2, 1, 0);
        add(0, 1, 0, 32'h0, 8'd0, 0, 1);

        foreach (tbl[k]) begin
            start       = tbl[k].start;
            instr_ready = tbl[k].ready;
            if (instr_valid && instr_ready)
                $display("xfer row %0d pc=%0d instr=%h", k, pc_out, instr_out);
            chk($sformatf("row%0d_valid", k), {31'd0, instr_valid}, {31'd0, tbl[k].valid});
            chk($sformatf("row%0d_instr", k), instr_out, tbl[k].instr);
            chk($sformatf("row%0d_pc", k), {24'd0, pc_out}, {24'd0, tbl[k].pc});
            chk($sformatf("row%0d_busy", k), {31'd0, busy}, {31'd0, tbl[k].busy});
            chk($sformatf("row%0d_done", k), {31'd0, done}, {31'd0, tbl[k].done});
            step();
            start = 1'b0;
        end

        // Halt word at address 1: only word 0 reaches downstream
        load(8'd0, 32'h0000_0011);
        load(8'd1, 32'hFFFF_FFFF);
        for (int a = 2; a <= 5; a++) load(8'(a), 32'h0000_0022 + 32'(a));
        prog[0] = 32'h0000_0011;
        last_pc = 8'd5;
        run_collect(1, 40, 1'b0, 1'b0);

        // Reset in cycle 4 of a 4-word run, then replay
        prog[0] = 32'h8001_0203;
        prog[1] = 32'h0004_0506;
        prog[2] = 32'h8008_090A;
        prog[3] = 32'h000B_0C0D;
        for (int a = 0; a < 4; a++) load(8'(a), prog[a]);
        last_pc     = 8'd3;
        start       = 1'b1;
        instr_ready = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();
        check_idle("midrst", 1'b0);
        reset = 1'b1;
        step();
        run_collect(4, 50, 1'b0, 1'b0);

        // start/load_en during FETCH ignored, then rerun proves imem intact
        run_collect(4, 50, 1'b0, 1'b1);
        last_pc = 8'd3;
        run_collect(4, 50, 1'b0, 1'b0);

        // Whole memory, random backpressure
        for (int a = 0; a < 256; a++) begin
            load(8'(a), 32'h0000_0001);
            prog[a] = 32'h0000_0001;
        end
        last_pc = 8'd255;
        run_collect(256, 3000, 1'b1, 1'b0);
        step();
        check_idle("after_full", 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
